// File: rtl/pingpong_fill_ctrl.sv
// Fill controller for a ping-pong RAM: writes producer beats into the fill bank,
// lets the last write commit, then swaps banks and hands the filled bank to the consumer.
module pingpong_fill_ctrl #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned WIDTH  = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              wr_en,
  output logic              switch,
  output logic              rd_start,
  output logic [ADDR_W:0]   rd_len,
  input  logic              rd_done
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {FILL, DRAIN, WAIT, SWAP} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] wr_cnt;
  logic [LEN_W-1:0]  len_r;
  logic              drain_cnt;
  logic              cons_busy;

  logic [LEN_W-1:0]  cfg_sat;
  logic [LEN_W-1:0]  len_eff;
  logic              accept;
  logic              last_beat;

  // Out-of-range lengths fall back to a full bank; the length is sampled until the first beat lands.
  always_comb begin
    cfg_sat = cfg_len;
    if ((cfg_len == '0) || (cfg_len > LEN_W'(DEPTH))) begin
      cfg_sat = LEN_W'(DEPTH);
    end
    len_eff   = (wr_cnt == '0) ? cfg_sat : len_r;
    accept    = in_valid && (state == FILL);
    last_beat = accept && (LEN_W'(wr_cnt) == (len_eff - LEN_W'(1)));
  end

  assign in_ready = (state == FILL) && !rst;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (last_beat) state_next = DRAIN;
      DRAIN:   if (drain_cnt) state_next = WAIT;
      WAIT:    if (!cons_busy || rd_done) state_next = SWAP;
      SWAP:    state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // Write port, bank handoff and consumer tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt    <= '0;
      len_r     <= LEN_W'(DEPTH);
      drain_cnt <= 1'b0;
      cons_busy <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      switch    <= 1'b0;
      rd_start  <= 1'b0;
      rd_len    <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= wr_cnt;
        wr_data <= in_data;
        wr_cnt  <= last_beat ? '0 : wr_cnt + ADDR_W'(1);
      end
      if ((state == FILL) && (wr_cnt == '0)) begin
        len_r <= cfg_sat;
      end
      drain_cnt <= (state == DRAIN) ? !drain_cnt : 1'b0;
      switch    <= (state_next == SWAP);
      rd_start  <= (state == SWAP);
      if (state == SWAP) begin
        rd_len <= len_r;
      end
      // A done pulse coinciding with rd_start belongs to the previous bank.
      if (state == SWAP) begin
        cons_busy <= 1'b1;
      end else if (rd_done && !rd_start) begin
        cons_busy <= 1'b0;
      end
    end
  end

endmodule
